banana_palette_encoder: RTL and testbench
=========================================

// Module: banana_palette_encoder
// PURPOSE
//  Inverse of the banana sprite palette lookup: takes RGB565 pixels and returns the 3-bit
//  palette index, for packing sprite art into index ROMs / on-chip capture. Sits between a
//  pixel source (capture/DMA) and an index-memory writer. Valid/ready on both sides.
//  Serial search over palette entries, one compare per cycle.
// PARAMETERS
//  NUM_ENTRIES  6  palette entries searched, indices 0..NUM_ENTRIES-1 (max 8)
//  KEY_INDEX    0  index emitted on miss without nearest-match (transparent key colour)
// PORTS
//  Clk        in   1   system clock
//  Reset_n    in   1   asynchronous, active-low reset
//  in_valid   in   1   pixel present on in_rgb
//  in_ready   out  1   encoder can accept a pixel
//  in_rgb     in   16  pixel, RGB565 {R[15:11],G[10:5],B[4:0]}
//  out_valid  out  1   result present
//  out_ready  in   1   consumer takes result
//  out_index  out  3   palette index
//  out_miss   out  1   1 = no exact palette match
// BEHAVIOUR
//  One clock; reset is asynchronous, active-low (Reset_n). All state updates on posedge Clk.
//  Palette (RGB565): 0=0x0E3B 1=0xA30F 2=0x3960 3=0x6A20 4=0xD4A0 5=0xF6A0.
//  Reset: state IDLE, in_ready=1, out_valid=0, out_index=0, out_miss=0, pixel reg=0,
//   best_idx=0, best_dist=8'hFF.
//  FSM IDLE -> SEARCH -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready (cycle T) latch in_rgb, idx=0, best_dist=FF -> SEARCH.
//   SEARCH: in_ready=0. Each cycle compare pixel with entry idx.
//    Exact match -> best_idx=idx, miss=0 -> DONE immediately (early exit).
//    Else, if dist < best_dist (strict; a tie keeps the lower index): update best.
//    idx==NUM_ENTRIES-1 with no match -> DONE, miss=1.
//   DONE: out_valid=1; out_index/out_miss are stable until out_valid&out_ready, then -> IDLE.
//  Latency: exact match at index k -> out_valid at T+2+k; miss -> T+1+NUM_ENTRIES
//   (T+7 at default). Min 3 cycles/pixel; no overlap of in/out handshakes.
//  Distance: 2*|dR| + |dG| + 2*|dB| (R,B doubled to equalise 5/6-bit ranges).
//   Unsigned, max 187, 8 bits, no saturation needed.
//  in_rgb is ignored outside IDLE. in_valid may drop without penalty.
//  out_ready held low: DONE persists indefinitely; outputs held.
//  Reset mid-search or in DONE: immediate return to reset values; in-flight pixel discarded.
//  Palette indices >= NUM_ENTRIES are never emitted.
// CONFIGURATION
//  BANANA_NEAREST_MATCH_EN defined: on miss, out_index = best_idx (minimum distance), out_miss=1.
//  Undefined: distance logic is not built; exact compare only; on miss,
//   out_index=KEY_INDEX, out_miss=1. Timing and handshake are the same in both builds.
// STRUCTURE
//  Package banana_palette_pkg: typedef logic[15:0] rgb565_t; typedef logic[2:0] pal_idx_t;
//   localparam rgb565_t BANANA_PALETTE[8]; NUM_COLORS=6; state enum {IDLE,SEARCH,DONE}.
//   The palette lookup and this encoder share the same palette table.
//  Sub-module banana_color_dist (combinational): rgb565_t a,b -> 8-bit distance, eq flag.
//   Instantiated once.
// TESTING
//  1 Exact: in_rgb=0xA30F accepted at T -> out_valid at T+3, out_index=1, out_miss=0.
//  2 Exact last entry: 0xF6A0 -> out_valid at T+7, index=5, miss=0; 0x0E3B -> T+2, index 0.
//  3 Miss: 0xF680 (R30,G52,B0) -> T+7, miss=1; with BANANA_NEAREST_MATCH_EN index=5
//    (dist 1); without it index=0.
//  4 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid/out_index stable,
//    in_ready=0; release -> IDLE next cycle, in_ready=1.
//  5 Reset mid-search: Reset_n low 2 cycles after accept -> out_valid=0 and in_ready=1
//    asynchronously; next pixel 0x6A20 encodes to index 3 at T'+5.
//  6 Stream of 100 random palette pixels with random in_valid/out_ready gaps -> every index
//    matches the scoreboard, miss=0, no drops or duplicates.

Source files
------------

// File: rtl/banana_palette_pkg.sv
// Shared banana sprite palette: RGB565 table, index/pixel types and encoder states.
// Used by the palette lookup and by banana_palette_encoder.
package banana_palette_pkg;

    typedef logic [15:0] rgb565_t;
    typedef logic [2:0]  pal_idx_t;

    localparam int NUM_COLORS = 6;

    // Entries 6 and 7 are unused fillers so a 3-bit index can address the table directly.
    localparam rgb565_t BANANA_PALETTE [8] = '{
        16'h0E3B, 16'hA30F, 16'h3960, 16'h6A20,
        16'hD4A0, 16'hF6A0, 16'h0000, 16'h0000
    };

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

endpackage

// File: rtl/banana_color_dist.sv
// Combinational RGB565 comparator: equality flag plus, when BANANA_NEAREST_MATCH_EN
// is defined, the weighted distance 2*|dR| + |dG| + 2*|dB| (max 187, fits 8 bits).
module banana_color_dist
    import banana_palette_pkg::*;
(
    input  rgb565_t    a,
    input  rgb565_t    b,
`ifdef BANANA_NEAREST_MATCH_EN
    output logic [7:0] dist,
`endif
    output logic       eq
);

    assign eq = (a == b);

`ifdef BANANA_NEAREST_MATCH_EN
    logic [4:0] dr;
    logic [5:0] dg;
    logic [4:0] db;

    always_comb begin
        dr = (a[15:11] > b[15:11]) ? a[15:11] - b[15:11] : b[15:11] - a[15:11];
        dg = (a[10:5]  > b[10:5])  ? a[10:5]  - b[10:5]  : b[10:5]  - a[10:5];
        db = (a[4:0]   > b[4:0])   ? a[4:0]   - b[4:0]   : b[4:0]   - a[4:0];
        // Red and blue are doubled so their 5-bit range weighs like the 6-bit green.
        dist = {2'b00, dr, 1'b0} + {2'b00, dg} + {2'b00, db, 1'b0};
    end
`endif

endmodule

// File: rtl/banana_palette_encoder.sv
// RGB565 -> 3-bit banana palette index, serial search one entry per cycle, valid/ready both sides.
// Define BANANA_NEAREST_MATCH_EN to report the closest entry on a miss instead of KEY_INDEX.
module banana_palette_encoder
    import banana_palette_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_COLORS,
    parameter int KEY_INDEX   = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_index,
    output logic        out_miss
);

    localparam pal_idx_t LAST_IDX = pal_idx_t'(NUM_ENTRIES - 1);

    state_t   state;
    state_t   state_next;
    rgb565_t  pixel;
    pal_idx_t idx;
    pal_idx_t miss_index;
    logic     eq;
    logic     last;

    assign last = (idx == LAST_IDX);

`ifdef BANANA_NEAREST_MATCH_EN
    logic [7:0] dist;
    logic [7:0] best_dist;
    pal_idx_t   best_idx;
    logic       closer;

    banana_color_dist u_dist (
        .a    (pixel),
        .b    (BANANA_PALETTE[idx]),
        .dist (dist),
        .eq   (eq)
    );

    // Strict compare: on a tie the earlier (lower) index is kept.
    assign closer     = (dist < best_dist);
    assign miss_index = closer ? idx : best_idx;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            best_idx  <= '0;
            best_dist <= 8'hFF;
        end else if (state == IDLE && in_valid) begin
            best_idx  <= '0;
            best_dist <= 8'hFF;
        end else if (state == SEARCH && closer) begin
            best_idx  <= idx;
            best_dist <= dist;
        end
    end
`else
    localparam pal_idx_t KEY_IDX = pal_idx_t'(KEY_INDEX);

    banana_color_dist u_dist (
        .a  (pixel),
        .b  (BANANA_PALETTE[idx]),
        .eq (eq)
    );

    assign miss_index = KEY_IDX;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SEARCH;
            end
            SEARCH: begin
                if (eq || last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!Reset_n) begin
            state     <= IDLE;
            pixel     <= '0;
            idx       <= '0;
            out_index <= '0;
            out_miss  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pixel <= in_rgb;
                        idx   <= '0;
                    end
                end
                SEARCH: begin
                    idx <= idx + 3'd1;
                    if (eq) begin
                        out_index <= idx;
                        out_miss  <= 1'b0;
                    end else if (last) begin
                        out_index <= miss_index;
                        out_miss  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_banana_palette_encoder.sv
// Self-checking bench for banana_palette_encoder: directed latency/index cases, backpressure,
// mid-search reset and a randomized stream against a behavioural palette model.
module tb_banana_palette_encoder;

    localparam int N_ENT = 6;
    localparam int KEY   = 0;
    localparam logic [15:0] PAL [6] = '{16'h0E3B, 16'hA30F, 16'h3960, 16'h6A20, 16'hD4A0, 16'hF6A0};
`ifdef BANANA_NEAREST_MATCH_EN
    localparam bit NEAREST = 1'b1;
`else
    localparam bit NEAREST = 1'b0;
`endif

    logic        Clk;
    logic        Reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_index;
    logic        out_miss;

    int n_total = 0;
    int n_bad   = 0;
    int stream_got = 0;
    int exp_q [$];

    banana_palette_encoder #(.NUM_ENTRIES(N_ENT), .KEY_INDEX(KEY)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_miss  (out_miss)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int absd(input int x, input int y);
        return (x > y) ? x - y : y - x;
    endfunction

    // Returns {miss, index} from the palette rules: first exact hit, else nearest or key.
    function automatic logic [3:0] model(input logic [15:0] p);
        int best = 1000;
        int bi   = 0;
        int d;
        for (int i = 0; i < N_ENT; i++) begin
            if (PAL[i] == p) return {1'b0, 3'(i)};
            d = 2 * absd(int'(p[15:11]), int'(PAL[i][15:11]))
              +     absd(int'(p[10:5]),  int'(PAL[i][10:5]))
              + 2 * absd(int'(p[4:0]),   int'(PAL[i][4:0]));
            if (d < best) begin
                best = d;
                bi   = i;
            end
        end
        return {1'b1, NEAREST ? 3'(bi) : 3'(KEY)};
    endfunction

    // Accept one pixel, then count clock edges until out_valid; returns sitting at a negedge.
    task automatic encode(input logic [15:0] rgb, output int lat, output bit ok);
        int w;
        ok  = 1'b0;
        lat = 0;
        w   = 0;
        @(negedge Clk);
        in_rgb   = rgb;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(negedge Clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        #1 in_valid = 1'b0;
        while (lat < 20) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge Clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [15:0] rgb, input int exp_lat,
                           input logic [2:0] exp_idx, input logic exp_miss);
        int lat;
        bit ok;
        encode(rgb, lat, ok);
        if (ok) begin
            check({tag, "_lat"},  32'(lat),       32'(exp_lat));
            check({tag, "_idx"},  32'(out_index), 32'(exp_idx));
            check({tag, "_miss"}, 32'(out_miss),  32'(exp_miss));
            take_result();
        end
    endtask

    initial begin
        int lat;
        bit ok;
        logic [15:0] px;
        logic [3:0]  m;

        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_rgb    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_miss",  32'(out_miss),  32'd0);
        Reset_n = 1'b1;

        // Exact hits: index k appears 1+k edges after the accepting edge.
        run_one("exact_a30f", 16'hA30F, 2, 3'd1, 1'b0);
        run_one("exact_f6a0", 16'hF6A0, 6, 3'd5, 1'b0);
        run_one("exact_0e3b", 16'h0E3B, 1, 3'd0, 1'b0);

        // Miss: all entries searched; nearest is entry 5 at distance 1.
        run_one("miss_f680", 16'hF680, N_ENT, NEAREST ? 3'd5 : 3'd0, 1'b1);

        // Backpressure in DONE.
        encode(16'hD4A0, lat, ok);
        if (ok) begin
            check("bp_lat", 32'(lat), 32'd5);
            for (int c = 0; c < 10; c++) begin
                @(negedge Clk);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_out_index", 32'(out_index), 32'd4);
                check("bp_in_ready",  32'(in_ready),  32'd0);
            end
            take_result();
            @(negedge Clk);
            check("bp_release_in_ready",  32'(in_ready),  32'd1);
            check("bp_release_out_valid", 32'(out_valid), 32'd0);
        end

        // Reset two cycles into a search takes effect without waiting for a clock edge.
        @(negedge Clk);
        in_rgb   = 16'h3960;
        in_valid = 1'b1;
        @(posedge Clk);
        #1 in_valid = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_index", 32'(out_index), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        run_one("after_rst_6a20", 16'h6A20, 4, 3'd3, 1'b0);

        // Arbitrary pixels against the model (mostly misses, exercising the miss policy).
        for (int i = 0; i < 20; i++) begin
            px = 16'($urandom);
            m  = model(px);
            run_one("rand_px", px, m[3] ? N_ENT : 1 + int'(m[2:0]), m[2:0], m[3]);
        end

        // Stream of palette pixels with random valid/ready gaps.
        fork
            begin : producer
                int k;
                int w;
                bit acc;
                for (int i = 0; i < 100; i++) begin
                    k   = $urandom_range(0, N_ENT - 1);
                    acc = 1'b0;
                    w   = 0;
                    while (!acc && w < 200) begin
                        @(negedge Clk);
                        in_rgb   = PAL[k];
                        in_valid = ($urandom_range(0, 3) != 0);
                        acc      = in_valid && in_ready;
                        w++;
                    end
                    if (!acc) begin
                        check("stream_accept_timeout", 32'(acc), 32'd1);
                        in_valid = 1'b0;
                        break;
                    end
                    @(posedge Clk);
                    exp_q.push_back(k);
                    #1 in_valid = 1'b0;
                end
            end
            begin : consumer
                int cyc;
                int e;
                cyc = 0;
                while (stream_got < 100 && cyc < 20000) begin
                    @(negedge Clk);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("stream_spurious", 32'(exp_q.size()), 32'd1);
                        end else begin
                            e = exp_q.pop_front();
                            check("stream_idx",  32'(out_index), 32'(e));
                            check("stream_miss", 32'(out_miss),  32'd0);
                        end
                        stream_got++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        check("stream_count",    32'(stream_got),   32'd100);
        check("stream_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
